// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deframer and its bit sampler.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_e;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam int SYNC_DEPTH = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversample counter and bit-value decision for the UART receiver.
// Macro UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic               rx_i,
    output logic               bit_o,
    output logic               sampleValid_o,
    output logic               bitDone_o
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

    logic [PRESC_W-1:0] edgeCnt_q, edgeCnt_d;
    logic [PRESC_W-1:0] half, last;
    logic               bit_q;

    assign half = presc_i >> 1;
    assign last = presc_i - ONE;

    always_comb begin
        edgeCnt_d = '0;
        if (run_i && edgeCnt_q != last) begin
            edgeCnt_d = edgeCnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edgeCnt_q <= '0;
        end else begin
            edgeCnt_q <= edgeCnt_d;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // The third vote is taken live from rx_i so the decision lands one edge after the last sample.
    logic s0_q, s1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
            bit_q <= 1'b1;
        end else begin
            if (edgeCnt_q == half - ONE) s0_q <= rx_i;
            if (edgeCnt_q == half) s1_q <= rx_i;
            if (edgeCnt_q == half + ONE) bit_q <= majority3(s0_q, s1_q, rx_i);
        end
    end

    assign sampleValid_o = run_i && (edgeCnt_q == half + TWO);
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_q <= 1'b1;
        end else if (edgeCnt_q == half) begin
            bit_q <= rx_i;
        end
    end

    assign sampleValid_o = run_i && (edgeCnt_q == half + ONE);
`endif

    assign bit_o     = bit_q;
    assign bitDone_o = run_i && (edgeCnt_q == last);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes RX_IN, walks start/data/parity/stop bits and reports each frame.
// Build with UART_RX_MAJORITY_VOTE_EN defined to enable majority-vote bit sampling.
module uart_rx_deframer
    import uart_rx_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [WIDTH-1:0]   P_DATA,
    output logic               DATA_VLD,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int              BCW      = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  rxS;
    rxState_e              state_q;
    logic [BCW-1:0]        bitCnt_q;
    logic [WIDTH-1:0]      shift_q;
    logic [PRESC_W-1:0]    presc_q;
    logic                  parEn_q, parTyp_q, parBad_q, stpBad_q;
    logic                  sampledBit, sampleValid, bitDone;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], RX_IN};
        end
    end

    assign rxS = sync_q[SYNC_DEPTH-1];

    uart_rx_sampler #(
        .PRESC_W(PRESC_W)
    ) u_sampler (
        .clk_i        (CLK),
        .rst_i        (RST),
        .run_i        (state_q != IDLE),
        .presc_i      (presc_q),
        .rx_i         (rxS),
        .bit_o        (sampledBit),
        .sampleValid_o(sampleValid),
        .bitDone_o    (bitDone)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            presc_q  <= PRESC_W'(PRESC_8);
            parEn_q  <= 1'b0;
            parTyp_q <= 1'b0;
            parBad_q <= 1'b0;
            stpBad_q <= 1'b0;
            P_DATA   <= '0;
            DATA_VLD <= 1'b0;
            PAR_ERR  <= 1'b0;
            STP_ERR  <= 1'b0;
        end else begin
            DATA_VLD <= 1'b0;
            PAR_ERR  <= 1'b0;
            STP_ERR  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxS) begin
                        state_q  <= START;
                        presc_q  <= PRESCALE;
                        parEn_q  <= PAR_EN;
                        parTyp_q <= PAR_TYP;
                        parBad_q <= 1'b0;
                        stpBad_q <= 1'b0;
                        bitCnt_q <= '0;
                    end
                end
                START: begin
                    // A start bit that reads high at mid-bit was only noise on the line.
                    if (sampleValid && sampledBit) begin
                        state_q <= IDLE;
                    end else if (bitDone) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (sampleValid) shift_q <= {sampledBit, shift_q[WIDTH-1:1]};
                    if (bitDone) begin
                        if (bitCnt_q == LAST_BIT) begin
                            bitCnt_q <= '0;
                            state_q  <= parEn_q ? PARITY : STOP;
                        end else begin
                            bitCnt_q <= bitCnt_q + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sampleValid) parBad_q <= sampledBit != (parTyp_q ? ~^shift_q : ^shift_q);
                    if (bitDone) state_q <= STOP;
                end
                STOP: begin
                    if (sampleValid) stpBad_q <= ~sampledBit;
                    if (bitDone) begin
                        DATA_VLD <= ~parBad_q & ~stpBad_q;
                        PAR_ERR  <= parBad_q;
                        STP_ERR  <= stpBad_q;
                        if (!parBad_q && !stpBad_q) P_DATA <= shift_q;
                        // A low line here is already the next start bit, so keep the bit grid running.
                        if (!rxS) begin
                            state_q  <= START;
                            parBad_q <= 1'b0;
                            stpBad_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side UART deframer. Sits directly upstream of the system controller.
- Oversamples the serial RX line and reassembles start, data, optional parity and stop bits.
- Delivers each good byte as P_DATA with a one-cycle DATA_VLD pulse; these drive the controller's UART_RX_DATA / UART_RX_VLD.
- Flags parity and stop (framing) errors; errored frames are never delivered.

Parameters:
- WIDTH, 8, data bits per frame; also the P_DATA width.
- PRESC_W, 6, width of the PRESCALE input and of the oversample edge counter.

Ports:
- CLK  in  1  oversampling clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_IN  in  1  asynchronous serial line; idles high.
- PRESCALE  in  PRESC_W  clocks per bit; legal values 8, 16, 32.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  WIDTH  last good byte, LSB received first.
- DATA_VLD  out  1  one-cycle pulse: P_DATA is new.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch.
- STP_ERR  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state=IDLE; edge and bit counters = 0.
  - P_DATA=0; DATA_VLD=PAR_ERR=STP_ERR=0.
  - Both synchronizer flops = 1.
  - A frame in progress is abandoned with no output pulse.
- Input path: RX_IN passes through a 2-flop synchronizer (rx_s). Nothing else reads RX_IN.
- Config latching: PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame have no effect.
- edge_cnt counts 0..PRESCALE-1 within each bit and wraps to 0 at each bit boundary.
- Sampling: the bit value is taken at edge_cnt = PRESCALE/2 and is used from edge_cnt = PRESCALE/2+1 onward.
- States:
  - IDLE: rx_s=0 -> START with edge_cnt=0.
  - START: at the sample point, bit=1 means a glitch -> IDLE, no outputs. Otherwise at edge_cnt=PRESCALE-1 -> DATA.
  - DATA: shift the sampled bit into the WIDTH-bit shift register, LSB first. After WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: expected bit = ^data for even, ~^data for odd. A mismatch sets an internal par_bad flag. At edge_cnt=PRESCALE-1 -> STOP.
  - STOP: sampled bit 0 sets stp_bad. At edge_cnt=PRESCALE-1 register the outputs (next bullet), then go to START if rx_s=0 (back-to-back frame), else IDLE.
- Outputs at the end of STOP:
  - DATA_VLD=1 and P_DATA=shift register, only if neither par_bad nor stp_bad is set.
  - PAR_ERR=par_bad; STP_ERR=stp_bad. Both may pulse in the same cycle.
  - P_DATA holds its old value on an errored frame.
  - All pulses last exactly one cycle.
- Latency:
  - Frame length in bits = 1 + WIDTH + PAR_EN + 1.
  - The pulses rise 2 + PRESCALE*bits rising edges after the edge that first samples RX_IN=0.
  - Example: PRESCALE=8, 8N1 -> 82 edges.
- Out-of-range PRESCALE (non-legal value, <4, or odd): behaviour undefined. Legality is the configuring register's responsibility.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: the bit value is the 2-of-3 majority of samples taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. It is valid from PRESCALE/2+2.
- Not defined: single sample at PRESCALE/2, as above.
- Frame timing and pulse latency are identical in both builds. The decision point is always at or before PRESCALE/2+2, and outputs are only registered at the end of STOP.

Decomposition:
- Package uart_rx_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - constants PRESC_8=8, PRESC_16=16, PRESC_32=32.
  - localparam for the synchronizer depth (2).
- Sub-module uart_rx_sampler:
  - contents: edge counter, sample/majority logic, bit_done and sample_valid strobes.
  - The parent FSM owns the bit counter, shift register, parity/stop checks and outputs.

Test Plan:
- PRESCALE=8, PAR_EN=0, frame 0xA3 (8N1):
  - P_DATA=0xA3 with DATA_VLD pulse 82 edges after the falling edge.
  - PAR_ERR=STP_ERR=0.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, frame 0x05 with parity=0: DATA_VLD, P_DATA=0x05.
- Same frame with parity=1: PAR_ERR pulse only; no DATA_VLD; P_DATA keeps its previous value.
- PRESCALE=32, frame 0xCC with stop bit driven 0: STP_ERR pulse only; the FSM then re-syncs and correctly receives a following 0xDD.
- 3-cycle low glitch on RX_IN at PRESCALE=16: no output pulses; a valid 0xBB sent immediately after is received.
- Back-to-back frames 0x0A, 0x05 with no idle gap at PRESCALE=8:
  - two DATA_VLD pulses exactly 80 cycles apart.
  - Assert RST in the middle of a third frame: no pulse for it, and all outputs read 0 the cycle after.
